const_time_multiply: RTL and testbench
======================================

// Module: const_time_multiply
// PURPOSE
//   Unsigned WIDTH x WIDTH -> 2*WIDTH sequential shift-add multiplier. Inverse companion of the secure divider.
//   Feeds the RSA modular-exponentiation datapath. Latency and switching activity are data-independent:
//   exactly WIDTH calc cycles for every operand pair (timing side-channel hardened).
// PARAMETERS
//   WIDTH   8   operand width in bits; legal range WIDTH >= 2
// PORTS
//   clk           in   1          clock, rising edge
//   rst_n         in   1          reset, asynchronous, active-low
//   start         in   1          request; sampled only in IDLE
//   multiplicand  in   WIDTH      operand A; latched on the accepted start
//   multiplier    in   WIDTH      operand B; latched on the accepted start
//   addend        in   WIDTH      operand C; present only with CT_MUL_ADDEND_EN
//   product       out  2*WIDTH    result A*B (+C); registered
//   busy          out  1          high while state == CALC
//   finish        out  1          one-cycle done pulse; registered
// BEHAVIOUR
//   Reset: state=IDLE; cnt=0; busy=0; finish=0; product=0; A_reg=0; acc=0.
//   State encoding: 1-bit. IDLE=0, CALC=1.
//   Accumulator: acc = {carry(1), hi(WIDTH), lo(WIDTH)}. product = {hi, lo}.
//   Transitions:
//     - IDLE & start: latch A_reg=multiplicand; hi=0 (or addend); lo=multiplier; carry=0; cnt=0; go to CALC.
//     - IDLE & !start: hold everything; product stays stable.
//     - CALC, every cycle:
//         sum = hi + (A_reg & {WIDTH{lo[0]}})          (WIDTH+1 bits)
//         {carry,hi,lo} <= {1'b0, sum, lo} >> 1
//         cnt <= cnt + 1
//     - CALC & cnt == WIDTH-1: go to IDLE; finish <= 1 on the same edge.
//   Constant time:
//     - The adder runs every CALC cycle; the operand is masked, not skipped.
//     - No early exit on zero operands or on a zero high part of B.
//   Latency: start sampled at edge 0; CALC steps occur at edges 1..WIDTH.
//     - finish is high for exactly 1 cycle following edge WIDTH.
//     - busy is high from after edge 0 until edge WIDTH.
//   product:
//     - Valid from the finish cycle; held until the next accepted start.
//     - Intermediate values while busy are not meaningful.
//   Handshake boundary cases:
//     - start while busy: ignored; operands are not re-latched and the timing is unchanged.
//     - start high during the finish cycle: accepted (state is already IDLE). Back-to-back throughput is WIDTH+1 cycles.
//     - Input operands may change freely after the accepting edge.
//   Widths: cnt is $clog2(WIDTH) bits. Overflow is impossible: (2^W-1)^2 + (2^W-1) < 2^(2W).
//   Reset mid-operation: the async clear aborts immediately. There is no finish pulse for the aborted job.
//     The first start after reset release is accepted normally.
// CONFIGURATION
//   CT_MUL_ADDEND_EN defined:
//     - Port addend exists; hi is preloaded with addend on start.
//     - product = A*B + C. Latency is unchanged.
//   CT_MUL_ADDEND_EN undefined:
//     - Port addend is absent; hi is preloaded with 0.
//     - product = A*B.
// TESTING (WIDTH=8)
//   1. A=255, B=255 -> product=16'hFE01; finish exactly 8 cycles after the start edge; busy high 8 cycles.
//   2. A=0, B=0x5A, then A=0xC3, B=1 -> product=0, then 0x00C3; both with identical 8-cycle latency.
//   3. start A=3, B=5; pulse start with A=9, B=9 at cycle 3 -> product=15; only one finish pulse.
//   4. start held high continuously, alternating operands -> a new job starts each finish cycle;
//      a finish pulse every 9 cycles; each product correct.
//   5. rst_n low at cycle 4 of a job -> finish=0, busy=0, product=0 asynchronously;
//      next start with 7*6 gives product=42.
//   6. CT_MUL_ADDEND_EN: A=255, B=255, C=255 -> product=16'hFF00; A=0, B=0, C=0x80 -> product=16'h0080.

Source files
------------

// File: rtl/const_time_multiply.sv
// Unsigned WIDTH x WIDTH -> 2*WIDTH shift-add multiplier with data-independent latency (WIDTH calc cycles).
// Optional feature macro CT_MUL_ADDEND_EN adds an addend port so that product = A*B + C.
module const_time_multiply #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
`ifdef CT_MUL_ADDEND_EN
  input  logic [WIDTH-1:0]   addend,
`endif
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               finish
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned SUM_W = WIDTH + 1;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_finish;
  logic [WIDTH-1:0] w_hi_init;
  logic [SUM_W-1:0] w_sum;
  logic             w_last;
  logic             w_load;
  logic             w_step;
  logic             w_finish_nxt;

`ifdef CT_MUL_ADDEND_EN
  assign w_hi_init = addend;
`else
  assign w_hi_init = '0;
`endif

  // Adder always runs; the multiplicand is masked by the current multiplier bit, never skipped.
  assign w_sum  = SUM_W'(r_hi) + SUM_W'(r_a & {WIDTH{r_lo[0]}});
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  // Next-state and control decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_finish_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = CALC;
        end
      end
      CALC: begin
        w_step = 1'b1;
        if (w_last) begin
          w_state_nxt  = IDLE;
          w_finish_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_finish <= 1'b0;
    end else begin
      if (w_load) begin
        r_a   <= multiplicand;
        r_hi  <= w_hi_init;
        r_lo  <= multiplier;
        r_cnt <= '0;
      end else if (w_step) begin
        // {carry,hi,lo} >> 1 with carry folded into the top of the sum.
        r_hi  <= w_sum[WIDTH:1];
        r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_busy   <= (w_state_nxt == CALC);
      r_finish <= w_finish_nxt;
    end
  end

  assign product = {r_hi, r_lo};
  assign busy    = r_busy;
  assign finish  = r_finish;

endmodule

// File: tb/tb_const_time_multiply.sv
// Directed bench for const_time_multiply (WIDTH=8) with an expected-product queue.
module tb_const_time_multiply;

  localparam int unsigned W = 8;
`ifdef CT_MUL_ADDEND_EN
  localparam bit HAS_ADD = 1'b1;
`else
  localparam bit HAS_ADD = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   multiplicand = '0;
  logic [W-1:0]   multiplier = '0;
  logic [W-1:0]   addend = '0;
  logic [2*W-1:0] product;
  logic           busy;
  logic           finish;

  logic [2*W-1:0] exp_q[$];
  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  const_time_multiply #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
`ifdef CT_MUL_ADDEND_EN
    .addend       (addend),
`endif
    .product      (product),
    .busy         (busy),
    .finish       (finish)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] c);
    logic [31:0] r;
    r = 32'(a) * 32'(b) + (HAS_ADD ? 32'(c) : 32'd0);
    return r[2*W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Wait (bounded) for a finish pulse; n counts edges waited, bn counts busy samples seen.
  task automatic wait_finish(input string tag, output int n, output int bn);
    n  = 0;
    bn = 0;
    while (!finish && n < 40) begin
      if (busy) bn++;
      tick();
      n++;
    end
    if (!finish) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic pop_check(input string tag);
    if (exp_q.size() == 0) check({tag, "_queue_empty"}, 32'd0, 32'd1);
    else check(tag, 32'(product), 32'(exp_q.pop_front()));
  endtask

  task automatic run_job(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c);
    int n;
    int bn;
    logic [2*W-1:0] held;
    start = 1'b1; multiplicand = a; multiplier = b; addend = c;
    exp_q.push_back(model(a, b, c));
    tick();
    start = 1'b0;
    multiplicand = W'($urandom); multiplier = W'($urandom); addend = W'($urandom);
    wait_finish(tag, n, bn);
    check({tag, "_latency"}, 32'(n), 32'(W));
    check({tag, "_busy_cycles"}, 32'(bn), 32'(W));
    pop_check({tag, "_product"});
    held = product;
    tick();
    check({tag, "_finish_one_cycle"}, 32'(finish), 32'd0);
    check({tag, "_product_held"}, 32'(product), 32'(held));
  endtask

  initial begin
    int n;
    int bn;
    int extra;
    int t_prev;
    logic [W-1:0] pa[4];
    logic [W-1:0] pb[4];

    // Reset state
    #12;
    check("rst_product", 32'(product), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_finish", 32'(finish), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1. Worst-case operands
    run_job("t1_ff_ff", 8'hFF, 8'hFF, 8'h00);

    // 2. Zero multiplicand and unit multiplier keep the same latency
    run_job("t2_zero", 8'h00, 8'h5A, 8'h00);
    run_job("t2_unit", 8'hC3, 8'h01, 8'h00);

    // 3. start while busy is ignored
    start = 1'b1; multiplicand = 8'd3; multiplier = 8'd5; addend = '0;
    exp_q.push_back(model(8'd3, 8'd5, 8'd0));
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1; multiplicand = 8'd9; multiplier = 8'd9;
    tick();
    start = 1'b0;
    wait_finish("t3", n, bn);
    check("t3_latency", 32'(n + 3), 32'(W));
    pop_check("t3_product");
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (finish) extra++;
    end
    check("t3_single_finish", 32'(extra), 32'd0);
    check("t3_idle", 32'(busy), 32'd0);

    // 4. start held high: a new job each finish cycle
    pa = '{8'h12, 8'hFE, 8'h00, 8'h81};
    pb = '{8'h34, 8'h03, 8'hFF, 8'h81};
    start = 1'b1; multiplicand = pa[0]; multiplier = pb[0];
    exp_q.push_back(model(pa[0], pb[0], addend));
    tick();
    t_prev = cyc;
    for (int j = 1; j <= 4; j++) begin
      if (j < 4) begin
        multiplicand = pa[j]; multiplier = pb[j];
        exp_q.push_back(model(pa[j], pb[j], addend));
      end else begin
        start = 1'b0;
      end
      wait_finish("t4", n, bn);
      check("t4_interval", 32'(cyc - t_prev), (j == 1) ? 32'(W) : 32'(W + 1));
      t_prev = cyc;
      pop_check("t4_product");
      tick();
    end
    check("t4_idle_after", 32'(busy), 32'd0);

    // 5. Asynchronous reset mid-job
    start = 1'b1; multiplicand = 8'd100; multiplier = 8'd200;
    exp_q.push_back(model(8'd100, 8'd200, addend));
    tick();
    start = 1'b0;
    repeat (3) tick();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_finish", 32'(finish), 32'd0);
    check("t5_async_busy", 32'(busy), 32'd0);
    check("t5_async_product", 32'(product), 32'd0);
    exp_q.delete();
    repeat (2) tick();
    check("t5_in_reset_finish", 32'(finish), 32'd0);
    rst_n = 1'b1;
    tick();
    run_job("t5_after_reset", 8'd7, 8'd6, 8'd0);

`ifdef CT_MUL_ADDEND_EN
    // 6. Addend boundaries
    run_job("t6_ff_ff_ff", 8'hFF, 8'hFF, 8'hFF);
    run_job("t6_addend_only", 8'h00, 8'h00, 8'h80);
`endif

    // Random operand pairs
    for (int k = 0; k < 4; k++) begin
      run_job("rand", W'($urandom), W'($urandom), W'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
